// File: rtl/matrix_arbiter_if.sv
// Requester/display bundle for the LED matrix arbiter.
// Requesters drive req, frames and tick; arbiter returns grant and frame.
interface matrix_arbiter_if;
  logic        tick;
  logic [2:0]  req;
  logic [35:0] img0;
  logic [35:0] img1;
  logic [35:0] img2;
  logic [2:0]  gnt;
  logic [35:0] img_out;
  logic        busy;

  modport master (
    output tick, req, img0, img1, img2,
    input  gnt, img_out, busy
  );

  modport slave (
    input  tick, req, img0, img1, img2,
    output gnt, img_out, busy
  );
endinterface

// File: rtl/matrix_arbiter.sv
// Fixed-priority 3-way owner of a 6x6 LED matrix with minimum hold
// time counted in tick pulses and a blank frame between owners.
module matrix_arbiter #(
  parameter int unsigned MIN_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  matrix_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [7:0] LP_HOLD = 8'(MIN_HOLD);

  state_t      r_state;
  logic [2:0]  r_gnt;
  logic [35:0] r_img;
  logic        r_busy;
  logic [7:0]  r_cnt;

  state_t      w_state_nx;
  logic [2:0]  w_gnt_nx;
  logic [35:0] w_img_nx;
  logic [7:0]  w_cnt_nx;
  logic [2:0]  w_pri;

  always_comb begin
    w_pri = 3'b000;
    if (bus.req[2])      w_pri = 3'b100;
    else if (bus.req[1]) w_pri = 3'b010;
    else if (bus.req[0]) w_pri = 3'b001;
  end

  function automatic logic [35:0] sel_img(
    input logic [2:0] g
  );
    logic [35:0] v;
    v = '0;
    unique case (1'b1)
      g[2]:    v = bus.img2;
      g[1]:    v = bus.img1;
      g[0]:    v = bus.img0;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_cnt_nx   = r_cnt;
    w_img_nx   = '0;
    unique case (r_state)
      IDLE, SWITCH: begin
        if (|bus.req) begin
          w_state_nx = OWN;
          w_gnt_nx   = w_pri;
          w_cnt_nx   = LP_HOLD;
          w_img_nx   = sel_img(w_pri);
        end else begin
          w_state_nx = IDLE;
          w_gnt_nx   = 3'b000;
          w_cnt_nx   = 8'd0;
        end
      end
      OWN: begin
        if (r_cnt != 8'd0) begin
          w_img_nx = sel_img(r_gnt);
          if (bus.tick) w_cnt_nx = r_cnt - 8'd1;
        end else if (w_pri == r_gnt) begin
          // owner still wins priority: keep it, no blank frame
          w_img_nx = sel_img(r_gnt);
        end else begin
          w_state_nx = SWITCH;
          w_gnt_nx   = 3'b000;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = 3'b000;
        w_cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 3'b000;
      r_img   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_img   <= w_img_nx;
      r_busy  <= |w_gnt_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.img_out = r_img;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_matrix_arbiter.sv
// Directed bench for matrix_arbiter: grant, hold, preemption,
// blank switch frame, live frame tracking and reset override.
module tb_matrix_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  matrix_arbiter_if bus ();

  matrix_arbiter #(.MIN_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(bus.gnt)) begin
        errors++;
        $display("FAIL onehot gnt=%b exp=onehot0", bus.gnt);
      end
      checks++;
      if (bus.busy !== (|bus.gnt)) begin
        errors++;
        $display("FAIL busy_eq busy=%b exp=%b", bus.busy, |bus.gnt);
      end
      if (bus.gnt === 3'b000) begin
        checks++;
        if (bus.img_out !== 36'h0) begin
          errors++;
          $display("FAIL blank img=%h exp=0", bus.img_out);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 3'b111;
    bus.tick = 1'b1;
    bus.img0 = 36'h1_1111_1111;
    bus.img1 = 36'h2_2222_2222;
    bus.img2 = 36'h3_3333_3333;
    step();
    step();
    checks++;
    if (bus.gnt !== 3'b000 || bus.img_out !== 36'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset gnt=%b img=%h busy=%b exp=000/0/0",
               bus.gnt, bus.img_out, bus.busy);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    bus.req = 3'b000;
    bus.tick = 1'b0;
    step();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle gnt=%b exp=000", bus.gnt);
    end
  endtask

  task automatic test_first_grant();
    bus.img0 = 36'h0_0000_0001;
    bus.req = 3'b001;
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL pre_grant gnt=%b exp=000", bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 3'b001 || bus.busy !== 1'b1 || bus.img_out !== 36'h1) begin
      errors++;
      $display("FAIL first_grant gnt=%b busy=%b img=%h exp=001/1/1",
               bus.gnt, bus.busy, bus.img_out);
    end
  endtask

  task automatic test_hold_preempt();
    bus.req = 3'b101;
    bus.img2 = 36'hA_AAAA_AAAA;
    bus.img0 = 36'h0_0000_0005;
    step();
    checks++;
    if (bus.gnt !== 3'b001 || bus.img_out !== 36'h5) begin
      errors++;
      $display("FAIL hold_track gnt=%b img=%h exp=001/5", bus.gnt, bus.img_out);
    end
    tick_step();
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL hold_t1 gnt=%b exp=001", bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL hold_gap gnt=%b exp=001", bus.gnt);
    end
    tick_step();
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL hold_t2 gnt=%b exp=001", bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 3'b000 || bus.img_out !== 36'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_switch gnt=%b img=%h busy=%b exp=000/0/0",
               bus.gnt, bus.img_out, bus.busy);
    end
    step();
    checks++;
    if (bus.gnt !== 3'b100 || bus.img_out !== 36'hA_AAAA_AAAA) begin
      errors++;
      $display("FAIL preempt_own gnt=%b img=%h exp=100/aaaaaaaaa",
               bus.gnt, bus.img_out);
    end
  endtask

  task automatic test_owner_steady();
    logic [35:0] v;
    bus.req = 3'b100;
    tick_step();
    tick_step();
    for (int i = 0; i < 4; i++) begin
      v = 36'h100 + 36'(i);
      bus.img2 = v;
      step();
      checks++;
      if (bus.gnt !== 3'b100 || bus.img_out !== v) begin
        errors++;
        $display("FAIL steady[%0d] gnt=%b img=%h exp=100/%h",
                 i, bus.gnt, bus.img_out, v);
      end
    end
    bus.req = 3'b000;
    step();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL steady_release gnt=%b exp=000", bus.gnt);
    end
    step();
  endtask

  task automatic test_release();
    bus.req = 3'b010;
    bus.img1 = 36'h0_0000_00F0;
    step();
    checks++;
    if (bus.gnt !== 3'b010 || bus.img_out !== 36'hF0) begin
      errors++;
      $display("FAIL rel_grant gnt=%b img=%h exp=010/f0", bus.gnt, bus.img_out);
    end
    bus.req = 3'b000;
    step();
    checks++;
    if (bus.gnt !== 3'b010) begin
      errors++;
      $display("FAIL rel_hold0 gnt=%b exp=010", bus.gnt);
    end
    tick_step();
    checks++;
    if (bus.gnt !== 3'b010) begin
      errors++;
      $display("FAIL rel_hold1 gnt=%b exp=010", bus.gnt);
    end
    tick_step();
    checks++;
    if (bus.gnt !== 3'b010) begin
      errors++;
      $display("FAIL rel_hold2 gnt=%b exp=010", bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rel_switch gnt=%b busy=%b exp=000/0", bus.gnt, bus.busy);
    end
    step();
    step();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL rel_idle gnt=%b exp=000", bus.gnt);
    end
  endtask

  task automatic test_tick_idle();
    tick_step();
    step();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL tick_idle gnt=%b exp=000", bus.gnt);
    end
  endtask

  task automatic test_back_to_back();
    bus.req = 3'b001;
    bus.img0 = 36'h3;
    step();
    tick_step();
    tick_step();
    step();
    checks++;
    if (bus.gnt !== 3'b001 || bus.img_out !== 36'h3) begin
      errors++;
      $display("FAIL b2b_keep gnt=%b img=%h exp=001/3", bus.gnt, bus.img_out);
    end
    bus.req = 3'b011;
    bus.img1 = 36'h7;
    step();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL b2b_switch gnt=%b exp=000", bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 3'b010 || bus.img_out !== 36'h7) begin
      errors++;
      $display("FAIL b2b_own gnt=%b img=%h exp=010/7", bus.gnt, bus.img_out);
    end
    bus.req = 3'b000;
    tick_step();
    tick_step();
    step();
    step();
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle gnt=%b exp=000", bus.gnt);
    end
  endtask

  task automatic test_priority_reset();
    bus.req = 3'b111;
    bus.img2 = 36'hF_0000_000F;
    step();
    checks++;
    if (bus.gnt !== 3'b100 || bus.img_out !== 36'hF_0000_000F) begin
      errors++;
      $display("FAIL prio gnt=%b img=%h exp=100/f0000000f", bus.gnt, bus.img_out);
    end
    step();
    bus.tick = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 3'b000 || bus.img_out !== 36'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset gnt=%b img=%h busy=%b exp=000/0/0",
               bus.gnt, bus.img_out, bus.busy);
    end
    bus.tick = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (bus.gnt !== 3'b100) begin
      errors++;
      $display("FAIL post_reset gnt=%b exp=100", bus.gnt);
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.req = 3'b000;
    bus.img0 = '0;
    bus.img1 = '0;
    bus.img2 = '0;
    #1;
    test_reset();
    test_first_grant();
    test_hold_preempt();
    test_owner_steady();
    test_release();
    test_tick_idle();
    test_back_to_back();
    test_priority_reset();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
